// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 4-way round-robin arbiter.
package mux4_rr_arbiter_pkg;

    localparam int N_REQ   = 4;
    localparam int SEL_W   = 2;
    localparam int BURST_W = 8;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant/data bundle between four serial sources and the arbiter.
interface mux4_rr_arbiter_if;
    import mux4_rr_arbiter_pkg::*;

    logic [N_REQ-1:0] req_i;
    logic [N_REQ-1:0] data_i;
    logic [N_REQ-1:0] gnt_o;
    logic [SEL_W-1:0] sel_o;
    logic             dout_o;
    logic             valid_o;
    logic             busy_o;

    modport master (
        output req_i, data_i,
        input  gnt_o, sel_o, dout_o, valid_o, busy_o
    );

    modport slave (
        input  req_i, data_i,
        output gnt_o, sel_o, dout_o, valid_o, busy_o
    );

endinterface

// File: rtl/mux2_cell.sv
// Basic 2:1 mux cell: y = s ? b : a.
module mux2_cell (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    assign y = s ? b : a;
endmodule

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first asserted request at or after start, with wrap,
// optionally skipping one index.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    input  logic             exclude_en,
    input  logic [SEL_W-1:0] exclude_idx,
    output logic             found,
    output logic [SEL_W-1:0] idx
);
    logic [N_REQ-1:0] masked;
    logic [SEL_W-1:0] cand [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand[gi] = start + SEL_W'(gi);
        end
    endgenerate

    assign masked = req & ~(exclude_en ? onehot(exclude_idx) : '0);

    // Scan from the farthest candidate back so the nearest one to start wins.
    always_comb begin
        found = 1'b0;
        idx   = start;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (masked[cand[k]]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter muxing one serial data bit from the granted source.
// Define ARB_BURST_LIMIT_EN to cap an owner at MAX_BURST granted cycles while others wait.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    mux4_rr_arbiter_if.slave  bus
);
    arb_state_t       state_reg;
    logic [SEL_W-1:0] last_owner_reg;
    logic [N_REQ-1:0] gnt_reg;
    logic [SEL_W-1:0] sel_reg;
    logic             dout_reg;
    logic             valid_reg;

    logic             owner_req;
    logic             burst_hit;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             qual;
    logic [1:0]       mux_l1;
    logic             mux_bit;

    assign owner_req = bus.req_i[last_owner_reg];

`ifdef ARB_BURST_LIMIT_EN
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    logic [BURST_W-1:0] burst_cnt_reg;
    logic               others_req;

    assign others_req = |(bus.req_i & ~onehot(last_owner_reg));
    assign burst_hit  = (state_reg == ST_GRANT) && owner_req && others_req
                        && (burst_cnt_reg >= BURST_LAST);
`else
    logic unused_cfg;
    assign unused_cfg = ^BURST_W'(MAX_BURST);
    assign burst_hit  = 1'b0;
`endif

    rr_pick4 u_pick (
        .req         (bus.req_i),
        .start       (last_owner_reg + SEL_W'(1)),
        .exclude_en  (burst_hit),
        .exclude_idx (last_owner_reg),
        .found       (pick_found),
        .idx         (pick_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mux_l1
            mux2_cell u_mux (
                .a (bus.data_i[2*gi]),
                .b (bus.data_i[2*gi+1]),
                .s (sel_reg[0]),
                .y (mux_l1[gi])
            );
        end
    endgenerate

    mux2_cell u_mux_l2 (
        .a (mux_l1[0]),
        .b (mux_l1[1]),
        .s (sel_reg[1]),
        .y (mux_bit)
    );

    // A bit is only forwarded while the current owner still asserts its request.
    assign qual = (|gnt_reg) && bus.req_i[sel_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            last_owner_reg <= SEL_W'(N_REQ - 1);
            gnt_reg        <= '0;
            sel_reg        <= '0;
            dout_reg       <= 1'b0;
            valid_reg      <= 1'b0;
`ifdef ARB_BURST_LIMIT_EN
            burst_cnt_reg  <= '0;
`endif
        end else begin
            valid_reg <= qual;
            dout_reg  <= qual & mux_bit;
            if ((state_reg == ST_GRANT) && owner_req && !burst_hit) begin
`ifdef ARB_BURST_LIMIT_EN
                if (burst_cnt_reg < BURST_LAST) begin
                    burst_cnt_reg <= burst_cnt_reg + BURST_W'(1);
                end
`endif
            end else if (pick_found) begin
                state_reg      <= ST_GRANT;
                gnt_reg        <= onehot(pick_idx);
                sel_reg        <= pick_idx;
                last_owner_reg <= pick_idx;
`ifdef ARB_BURST_LIMIT_EN
                burst_cnt_reg  <= '0;
`endif
            end else begin
                state_reg <= ST_IDLE;
                gnt_reg   <= '0;
            end
        end
    end

    assign bus.gnt_o   = gnt_reg;
    assign bus.sel_o   = sel_reg;
    assign bus.dout_o  = dout_reg;
    assign bus.valid_o = valid_reg;
    assign bus.busy_o  = |gnt_reg;

endmodule
